regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a self-clearing start-up sweep. It succeeds the single-write, dual-read register file in the core's decode/writeback path. It adds:
- configurable width, depth and read-port count;
- up to two write ports for dual-issue writeback;
- optional write-to-read bypass;
- a `ready` flag;
- a software/pipeline-triggerable `clr` that re-runs the zeroing sweep.

## Interface
Parameters:
- `XLEN`, 32: data width in bits.
- `NREGS`, 32: register count; power of two, ≥ 2; entry 0 reads as zero.
- `NREAD`, 2: number of read ports, 1–4.
- `NWRITE`, 1: number of write ports, 1 or 2.
- `BYPASS`, 0: 1 forwards same-cycle write data to matching reads.

Ports (`AW = $clog2(NREGS)`):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  restart the zeroing sweep.
- `rs`  in  NREAD×AW  read addresses.
- `rdata`  out  NREAD×XLEN  read data.
- `we`  in  NWRITE  per-port write enable.
- `rd`  in  NWRITE×AW  write addresses.
- `wdata`  in  NWRITE×XLEN  write data.
- `ready`  out  1  high when the sweep is complete and writes are accepted.

## Operation
- Sweep counter `cnt` is AW+1 bits wide. `ready = (cnt == NREGS)`, driven directly from the register.
- Reset and clear:
  - `rst` high sets `cnt` to 0.
  - `clr` high while `rst` is low also sets `cnt` to 0; `rst` takes precedence over `clr`.
  - `clr` while a sweep is in progress restarts the sweep at entry 0.
- Sweep: each cycle with `cnt != NREGS` and no `rst`/`clr`, entry `cnt` is zeroed in every storage copy and `cnt` increments. The sweep ends at `cnt == NREGS`.
- Writes:
  - Accepted only when `ready` is high and `clr` is low; otherwise silently dropped.
  - Writes to entry 0 are ignored.
  - When both ports target the same `rd`, port 1 wins.
- Reads:
  - Combinational. `rdata[i]` = entry `rs[i]`.
  - Forced to 0 when `rs[i] == 0` or `ready` is low.
- Bypass (BYPASS=1): if a write is accepted this cycle to `rd[j] == rs[i] != 0`, `rdata[i] = wdata[j]`. When both write ports match, port 1's data is forwarded.
- Without bypass (BYPASS=0): the written value becomes visible in the cycle after the write edge.
- Storage is one copy per read port. All copies receive identical writes and sweeps.

## Timing
- Reset values: `cnt` = 0, so `ready` = 0 and all `rdata` = 0.
- With `rst` sampled high at edge E0 and low afterwards:
  - Edges E1…E_NREGS clear entries 0…NREGS-1.
  - `ready` rises after E_NREGS.
  - The first write is accepted at E_NREGS+1.
- `clr` sampled at edge Ek gives `ready` = 0 from Ek through E_k+NREGS. A write presented in the same cycle as `clr` is dropped.
- Read latency is 0 cycles, combinational from `rs`. Write latency is 1 edge.
- A read and a write to the same entry in the same cycle return:
  - the old value with BYPASS=0;
  - the new value with BYPASS=1.
- `rst` asserted mid-sweep or mid-operation takes effect at the next edge. Register contents are not guaranteed until the following sweep completes; reads return 0 meanwhile.

## Structure
- `regfile_pkg` holds:
  - default parameter constants `XLEN_D`, `NREGS_D`;
  - the `regaddr_t` / `xword_t` typedefs for the 32×32 configuration.
- Sub-module `regfile_bank`, instantiated NREAD times:
  - one distributed-RAM copy with one combinational read port;
  - the NWRITE write ports with port-1 priority;
  - a sweep-clear input.
- The top level owns the sweep counter, the write-accept gating, zero/ready masking and the bypass muxes.

## Test plan
- Reset, then write 0xDEADBEEF to x5 one cycle after `ready` rises → `ready` is low for exactly 32 cycles after reset. Reading x5 (`rs[0]` = 5) returns 0xDEADBEEF the following cycle.
- Write 0x12345678 to x0, then read x0 on both ports → 0x00000000.
- NWRITE=2, same cycle writes x7 = 0xAAAA0000 (port 0) and x7 = 0x0000BBBB (port 1) → x7 reads 0x0000BBBB.
- BYPASS=1, write x9 = 0xCAFEF00D while `rs[1]` = 9 → `rdata[1]` = 0xCAFEF00D in the same cycle. With BYPASS=0 the same stimulus returns the old value.
- Fill x1–x31 with nonzero data, pulse `clr` with a simultaneous write to x3:
  - the write is dropped;
  - `ready` is low for 32 cycles;
  - afterwards all registers read 0.
- Pulse `clr` again 10 cycles into a sweep → the sweep restarts and `ready` rises 32 cycles after the second pulse. A write attempted during the sweep is dropped.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;

  typedef logic [$clog2(NREGS_D)-1:0] regaddr_t;
  typedef logic [XLEN_D-1:0]          xword_t;

endpackage

// File: rtl/regfile_bank.sv
// One storage copy of the register file: a single combinational read port,
// NWRITE write ports (higher port index wins) and a one-entry-per-cycle clear.
module regfile_bank #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NWRITE = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   rd,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic                   sweep,
  input  logic [AW-1:0]          sweep_addr,
  input  logic [AW-1:0]          raddr,
  output logic [XLEN-1:0]        rdata
);

  logic [XLEN-1:0] mem [NREGS];

  // Sweep and accepted writes never coincide: writes need the sweep finished.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[sweep_addr] <= '0;
    end else begin
      for (int j = 0; j < int'(NWRITE); j++) begin
        if (we[j]) begin
          mem[rd[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: sweep counter, write-accept gating, zero/ready
// masking and optional same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_D,
  parameter int unsigned NREGS  = NREGS_D,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 0,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NREAD*AW-1:0]    rs,
  output logic [NREAD*XLEN-1:0]  rdata,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   rd,
  input  logic [NWRITE*XLEN-1:0] wdata,
  output logic                   ready
);

  localparam logic [AW:0] CntDone = (AW+1)'(NREGS);

  logic [AW:0]        cnt_q, cnt_d;
  logic               sweep_en;
  logic [NWRITE-1:0]  we_acc;
  logic [XLEN-1:0]    bank_rdata [NREAD];

  assign ready    = (cnt_q == CntDone);
  assign sweep_en = !rst && !clr && !ready;

  always_comb begin
    cnt_d = cnt_q;
    if (rst || clr) begin
      cnt_d = '0;
    end else if (!ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  // Entry 0 is never written, so it needs no special case in the banks.
  always_comb begin
    we_acc = '0;
    for (int j = 0; j < int'(NWRITE); j++) begin
      we_acc[j] = we[j] && ready && !clr && (rd[j*AW +: AW] != '0);
    end
  end

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_bank
    regfile_bank #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWRITE (NWRITE)
    ) u_bank (
      .clk        (clk),
      .we         (we_acc),
      .rd         (rd),
      .wdata      (wdata),
      .sweep      (sweep_en),
      .sweep_addr (cnt_q[AW-1:0]),
      .raddr      (rs[i*AW +: AW]),
      .rdata      (bank_rdata[i])
    );
  end

  // Later write ports override earlier ones, matching bank write priority.
  always_comb begin
    logic [XLEN-1:0] val;
    rdata = '0;
    val   = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      val = bank_rdata[i];
      if (BYPASS != 0) begin
        for (int j = 0; j < int'(NWRITE); j++) begin
          if (we_acc[j] && (rd[j*AW +: AW] == rs[i*AW +: AW])) begin
            val = wdata[j*XLEN +: XLEN];
          end
        end
      end
      if (!ready || (rs[i*AW +: AW] == '0)) begin
        val = '0;
      end
      rdata[i*XLEN +: XLEN] = val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding
// instance share stimulus; expected values flow through a scoreboard queue.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [9:0]  rs = '0;
  logic [1:0]  we = '0;
  logic [9:0]  rd = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata_b, rdata_n;
  logic        ready_b, ready_n;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .rs(rs), .rdata(rdata_b),
    .we(we), .rd(rd), .wdata(wdata), .ready(ready_b)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .clr(clr), .rs(rs), .rdata(rdata_n),
    .we(we), .rd(rd), .wdata(wdata), .ready(ready_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic drive_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
    we    = en;
    rd    = {a1, a0};
    wdata = {d1, d0};
  endtask

  // Counts cycles with ready low, optionally attempting a write at step wr_step.
  task automatic count_low(output int low, input int wr_step);
    low = 0;
    while (ready_b !== 1'b1 && low < 100) begin
      low++;
      if (low == wr_step) drive_wr(2'b01, 5'd4, 32'hBAD0BAD0, 5'd0, 32'h0);
      else                drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
    end
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    int low;

    // Reset
    rst = 1'b1;
    rs  = {5'd5, 5'd5};
    tick();
    exp_q.push_back(32'h0); chk("rst_ready", {31'h0, ready_b});
    exp_q.push_back(32'h0); chk("rst_rdata", rdata_b[31:0]);
    rst = 1'b0;
    count_low(low, 0);
    exp_q.push_back(32'd32); chk("init_sweep_len", low);
    exp_q.push_back(32'h1); chk("init_ready_n", {31'h0, ready_n});

    // First write one cycle after ready; same-cycle read of x5
    drive_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'hDEADBEEF); chk("x5_bypass_same", rdata_b[31:0]);
    exp_q.push_back(32'h0);        chk("x5_nobyp_same", rdata_n[31:0]);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'hDEADBEEF); chk("x5_next_b", rdata_b[31:0]);
    exp_q.push_back(32'hDEADBEEF); chk("x5_next_n", rdata_n[31:0]);

    // Write to x0 is ignored, also by the bypass path
    rs = {5'd0, 5'd0};
    drive_wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'h0); chk("x0_bypass", rdata_b[31:0]);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'h0); chk("x0_p0", rdata_n[31:0]);
    exp_q.push_back(32'h0); chk("x0_p1", rdata_n[63:32]);

    // Dual write to x7: port 1 wins, in storage and in the bypass path
    rs = {5'd7, 5'd5};
    drive_wr(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h0000BBBB);
    #1;
    exp_q.push_back(32'h0000BBBB); chk("x7_bypass", rdata_b[63:32]);
    exp_q.push_back(32'h0);        chk("x7_nobyp_old", rdata_n[63:32]);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'h0000BBBB); chk("x7_b", rdata_b[63:32]);
    exp_q.push_back(32'h0000BBBB); chk("x7_n", rdata_n[63:32]);

    // x9 bypass vs old value
    rs = {5'd9, 5'd0};
    drive_wr(2'b01, 5'd9, 32'hCAFEF00D, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'hCAFEF00D); chk("x9_bypass", rdata_b[63:32]);
    exp_q.push_back(32'h0);        chk("x9_nobyp", rdata_n[63:32]);
    tick();
    drive_wr(2'b01, 5'd9, 32'h11112222, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'h11112222); chk("x9_bypass2", rdata_b[63:32]);
    exp_q.push_back(32'hCAFEF00D); chk("x9_nobyp_old", rdata_n[63:32]);
    tick();

    // Fill x1..x31, then read back
    for (int i = 1; i < 32; i++) begin
      drive_wr(2'b01, 5'(i), 32'hA5000000 + i, 5'd0, 32'h0);
      tick();
    end
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      rs = {5'(32 - i), 5'(i)};
      #1;
      exp_q.push_back(32'hA5000000 + i);        chk("fill_p0", rdata_n[31:0]);
      exp_q.push_back(32'hA5000000 + 32 - i);   chk("fill_p1", rdata_b[63:32]);
    end

    // clr with simultaneous write to x3: write dropped, not forwarded
    rs  = {5'd3, 5'd3};
    clr = 1'b1;
    drive_wr(2'b01, 5'd3, 32'h77777777, 5'd0, 32'h0);
    #1;
    exp_q.push_back(32'hA5000003); chk("clr_no_fwd", rdata_b[63:32]);
    tick();
    clr = 1'b0;
    count_low(low, 0);
    exp_q.push_back(32'd32); chk("clr_sweep_len", low);
    for (int i = 0; i < 32; i++) begin
      rs = {5'(i), 5'(i)};
      #1;
      exp_q.push_back(32'h0); chk("clr_zero_n", rdata_n[31:0]);
      exp_q.push_back(32'h0); chk("clr_zero_b", rdata_b[63:32]);
    end

    // Restart a sweep 10 cycles in; a write attempted mid-sweep is dropped
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    exp_q.push_back(32'h0); chk("mid_sweep_ready", {31'h0, ready_b});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    count_low(low, 10);
    exp_q.push_back(32'd32); chk("restart_sweep_len", low);
    rs = {5'd4, 5'd4};
    #1;
    exp_q.push_back(32'h0); chk("sweep_wr_drop_n", rdata_n[31:0]);
    exp_q.push_back(32'h0); chk("sweep_wr_drop_b", rdata_b[63:32]);

    // Reset asserted mid-operation: reads forced to 0 next cycle
    rs = {5'd0, 5'd0};
    drive_wr(2'b01, 5'd12, 32'h5A5A5A5A, 5'd0, 32'h0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rs  = {5'd12, 5'd12};
    rst = 1'b1;
    #1;
    exp_q.push_back(32'h5A5A5A5A); chk("pre_rst_read", rdata_n[31:0]);
    tick();
    rst = 1'b0;
    #1;
    exp_q.push_back(32'h0); chk("post_rst_read", rdata_n[31:0]);
    exp_q.push_back(32'h0); chk("post_rst_ready", {31'h0, ready_n});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
